// File: rtl/cache_mem_responder.sv
// Word-organised memory responder for the cache request interface with programmable latency.
// Optional macro MEM_STALL_EN adds 0..3 pseudo-random extra BUSY cycles per request.
module cache_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 4,
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_req_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_req_vaild,
    input  logic        mem_req_wr,
    output logic [31:0] mem_req_data,
    output logic        mem_req_ready,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_q, data_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic [4:0]          extra;
    logic [4:0]          load_val;

    // Contents survive rst; only power-up establishes INIT_VAL.
    logic [31:0] mem_array [DEPTH] = '{default: INIT_VAL};

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr[31:ADDR_W+2], mem_req_addr[1:0]};

`ifdef MEM_STALL_EN
    logic [3:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 4'b1001;
        else      lfsr_q <= lfsr_d;
    end

    assign extra = {3'b000, lfsr_q[1:0]};
`else
    assign extra = 5'd0;
`endif

    assign load_val = 5'(LATENCY - 1) + extra;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;

        case (state_q)
            IDLE: begin
                if (mem_req_vaild) begin
                    addr_d  = mem_req_addr[ADDR_W+1:2];
                    wr_d    = mem_req_wr;
                    wdata_d = mem_wr_data;
                    cnt_d   = load_val;
                    state_d = (load_val == 5'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = RESP;
            end
            RESP: begin
                cnt_d   = 5'd0;
                state_d = DRAIN;
                if (wr_q) begin
                    if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
                end else begin
                    if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
                end
            end
            DRAIN: begin
                // Wait for the initiator to drop valid so one request is served once.
                if (!mem_req_vaild) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Read data is registered on the edge that enters RESP.
        if (state_d == RESP && state_q != RESP && !wr_d) begin
            data_d = mem_array[addr_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // A write commits only on the edge leaving RESP, so a reset before then discards it.
    always_ff @(posedge clk) begin
        if (state_q == RESP && wr_q) begin
            mem_array[addr_q] <= wdata_q;
        end
    end

    assign mem_req_data  = data_q;
    assign mem_req_ready = (state_q == RESP);
    assign rd_count      = rd_count_q;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: vector table plus reset/abort/early-drop sequences.
// Build with MEM_STALL_EN defined to check the LFSR-driven extra latency.
module tb_cache_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req_vaild;
    logic        mem_req_wr;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(
        .ADDR_W  (10),
        .LATENCY (LAT),
        .INIT_VAL(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_addr (mem_req_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_req_vaild(mem_req_vaild),
        .mem_req_wr   (mem_req_wr),
        .mem_req_data (mem_req_data),
        .mem_req_ready(mem_req_ready),
        .rd_count     (rd_count),
        .wr_count     (wr_count)
    );

`ifdef MEM_STALL_EN
    // Reference x^4+x^3+1 sequence, seed 4'b1001, stepping every clock.
    logic [3:0] lfsr_m;
    always @(posedge clk or negedge rst) begin
        if (!rst) lfsr_m <= 4'b1001;
        else      lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    end
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        int          hold;
        logic [31:0] exp_data;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int expected_latency();
        int l;
        l = LAT;
`ifdef MEM_STALL_EN
        l = LAT + int'(lfsr_m[1:0]);
`endif
        return l;
    endfunction

    // Called one step after a rising edge with the DUT in IDLE; returns in IDLE.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input int hold, input logic [31:0] exp_data,
                           input logic [15:0] exp_rd, input logic [15:0] exp_wr);
        int          lat;
        int          exp_lat;
        logic [31:0] got;
        exp_lat       = expected_latency();
        mem_req_addr  = addr;
        mem_wr_data   = wdata;
        mem_req_wr    = wr;
        mem_req_vaild = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!mem_req_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got = mem_req_data;
        chk("latency", 32'(lat), 32'(exp_lat));
`ifdef MEM_STALL_EN
        chk("latency_range", {31'd0, (lat >= 4 && lat <= 7)}, 32'd1);
`endif
        chk("resp_data", got, exp_data);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("no_second_ready", {31'd0, mem_req_ready}, 32'd0);
        end
        mem_req_vaild = 1'b0;
        if (hold == 0) begin
            @(posedge clk); #1;
            chk("drain_ready_low", {31'd0, mem_req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        chk("rd_count", {16'd0, rd_count}, {16'd0, exp_rd});
        chk("wr_count", {16'd0, wr_count}, {16'd0, exp_wr});
        $display("req addr=%h wr=%b wdata=%h lat=%0d data=%h rd=%0d wr=%0d",
                 addr, wr, wdata, lat, got, rd_count, wr_count);
    endtask

    initial begin
        int lat;
        int exp_lat;

        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 0, 32'h0000_0000, 16'd0, 16'd1};
        vecs[1]  = '{32'h0000_0010, 32'h0000_0000, 1'b0, 0, 32'hDEAD_BEEF, 16'd1, 16'd1};
        vecs[2]  = '{32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1, 32'hDEAD_BEEF, 16'd1, 16'd2};
        vecs[3]  = '{32'h0000_0020, 32'h0000_0000, 1'b0, 0, 32'hCAFE_F00D, 16'd2, 16'd2};
        vecs[4]  = '{32'h0000_1004, 32'h1234_5678, 1'b1, 0, 32'hCAFE_F00D, 16'd2, 16'd3};
        vecs[5]  = '{32'h0000_0007, 32'h0000_0000, 1'b0, 2, 32'h1234_5678, 16'd3, 16'd3};
        vecs[6]  = '{32'h0000_0014, 32'hA5A5_A5A5, 1'b1, 0, 32'h1234_5678, 16'd3, 16'd4};
        vecs[7]  = '{32'hFFFF_F008, 32'h0BAD_F00D, 1'b1, 3, 32'h1234_5678, 16'd3, 16'd5};
        vecs[8]  = '{32'h0000_0008, 32'h0000_0000, 1'b0, 0, 32'h0BAD_F00D, 16'd4, 16'd5};
        vecs[9]  = '{32'h0000_03FC, 32'h0000_0000, 1'b0, 0, 32'h0000_0000, 16'd5, 16'd5};
        vecs[10] = '{32'h0000_0014, 32'h0000_0000, 1'b0, 0, 32'hA5A5_A5A5, 16'd6, 16'd5};
        vecs[11] = '{32'h0000_0010, 32'h0000_0000, 1'b0, 0, 32'hDEAD_BEEF, 16'd7, 16'd5};
        vecs[12] = '{32'h0000_1010, 32'h0000_0000, 1'b0, 0, 32'hDEAD_BEEF, 16'd8, 16'd5};

        rst           = 1'b0;
        mem_req_addr  = 32'd0;
        mem_wr_data   = 32'd0;
        mem_req_vaild = 1'b0;
        mem_req_wr    = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_ready", {31'd0, mem_req_ready}, 32'd0);
        chk("reset_data", mem_req_data, 32'd0);
        chk("reset_rd_count", {16'd0, rd_count}, 32'd0);
        chk("reset_wr_count", {16'd0, wr_count}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].hold,
                    vecs[i].exp_data, vecs[i].exp_rd, vecs[i].exp_wr);
        end

        // Valid drops during BUSY and inputs change: request still completes as latched.
        exp_lat       = expected_latency();
        mem_req_addr  = 32'h0000_0030;
        mem_wr_data   = 32'h7777_7777;
        mem_req_wr    = 1'b1;
        mem_req_vaild = 1'b1;
        @(posedge clk); #1;
        mem_req_vaild = 1'b0;
        mem_req_addr  = 32'h0000_0040;
        mem_wr_data   = 32'h5555_5555;
        mem_req_wr    = 1'b0;
        lat = 1;
        while (!mem_req_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("early_drop_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("early_drop_wr_count", {16'd0, wr_count}, 32'd6);
        chk("early_drop_rd_count", {16'd0, rd_count}, 32'd8);
        $display("req early-drop write addr=00000030 lat=%0d rd=%0d wr=%0d", lat, rd_count, wr_count);
        run_req(32'h0000_0030, 32'd0, 1'b0, 0, 32'h7777_7777, 16'd9, 16'd6);
        run_req(32'h0000_0040, 32'd0, 1'b0, 0, 32'h0000_0000, 16'd10, 16'd6);
        run_req(32'h0000_0010, 32'd0, 1'b0, 0, 32'hDEAD_BEEF, 16'd11, 16'd6);

        // Reset during BUSY of a write to word 5 must leave the old contents.
        mem_req_addr  = 32'h0000_0014;
        mem_wr_data   = 32'hFFFF_FFFF;
        mem_req_wr    = 1'b1;
        mem_req_vaild = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_reset_ready", {31'd0, mem_req_ready}, 32'd0);
        chk("async_reset_data", mem_req_data, 32'd0);
        chk("async_reset_rd_count", {16'd0, rd_count}, 32'd0);
        chk("async_reset_wr_count", {16'd0, wr_count}, 32'd0);
        $display("req reset mid-write addr=00000014 data=%h rd=%0d wr=%0d", mem_req_data, rd_count, wr_count);
        mem_req_vaild = 1'b0;
        mem_req_wr    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_req(32'h0000_0014, 32'd0, 1'b0, 0, 32'hA5A5_A5A5, 16'd1, 16'd0);

        // Twenty reads: latency follows the stall sequence when enabled, else fixed.
        for (int i = 0; i < 20; i++) begin
            run_req(32'h0000_0010, 32'd0, 1'b0, 0, 32'hDEAD_BEEF, 16'(i + 2), 16'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
